// File: rtl/shared_reg_pkg.sv
// Shared definitions for the round-robin shared-register write arbiter.
package shared_reg_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Width of the committed-write counter.
  localparam int unsigned COUNT_W = 16;

  // Bits needed to index n requesters (never less than one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    found  = |req;
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % int'(NUM_REQ)]) begin
        winner = IDX_W'((int'(ptr) + i) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register between NUM_REQ requesters.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WIDTH-1:0]       wdata,
  input  logic                           clear,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ack,
  output logic [WIDTH-1:0]               q,
  output logic [idx_width(NUM_REQ)-1:0]  owner,
  output logic                           busy,
  output logic [COUNT_W-1:0]             write_count
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ReqOne = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [COUNT_W-1:0]   count_q;
  logic                 count_en;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_winner;
  logic [WIDTH-1:0]     slice [NUM_REQ];
  logic                 win_req;
  logic                 commit;

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_slice
    assign slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  // Granted requester still holding its request; clear aborts a pending commit.
  assign win_req = req[win_q];
  assign commit  = (state_q == StGrant) && win_req && !clear;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> GRANT on any request, GRANT -> COMMIT or back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pick_found) state_d = StGrant;
      StGrant:  state_d = commit ? StCommit : StIdle;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and bookkeeping registers.
  always_comb begin
    grant_d  = '0;
    ack_d    = '0;
    win_d    = win_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    count_en = 1'b0;
    if ((state_q == StIdle) && pick_found) begin
      grant_d = ReqOne << pick_winner;
      win_d   = pick_winner;
    end
    if (commit) begin
      ack_d    = ReqOne << win_q;
      data_d   = slice[win_q];
      owner_d  = win_q;
      count_en = 1'b1;
      ptr_d    = (win_q == LastIdx) ? '0 : win_q + 1'b1;
    end
    // Clear always wins over a same-edge commit of the data.
    if (clear) data_d = '0;
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      if (count_en) count_q <= count_q + 1'b1;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign q           = data_q;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);
  assign write_count = count_q;

endmodule
